// File: rtl/scan_pkg.sv
// Shared types and widths for the temperature sensor scan path.
package scan_pkg;

    localparam int TEMP_W = 6;
    localparam int FRAC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_GAP     = 2'd3
    } scan_state_t;

    // Temperature part of a reading; the channel field is added where CH_W is known.
    typedef struct packed {
        logic [TEMP_W-1:0] temp;
        logic [FRAC_W-1:0] frac;
    } sample_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-start prescaler: one-cycle tick every SCAN_DIV cycles while enabled.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Periodic scan of NUM_CH temperature sensors through one shared req/ack sampler.
//
// state      | meaning
// ST_IDLE    | waiting for a scan tick
// ST_REQ     | smp_req high for channel ch, waiting for ack or timeout
// ST_CAPTURE | latched reading presented on mon_* with mon_valid
// ST_GAP     | one cycle with smp_req low before next channel / end of scan
module sensor_scan_ctrl
    import scan_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int SCAN_DIV = 1000,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              smp_req,
    output logic [CH_W-1:0]   smp_ch,
    input  logic              smp_ack,
    input  logic [TEMP_W-1:0] smp_temp,
    input  logic [FRAC_W-1:0] smp_frac,
    output logic              mon_valid,
    output logic [CH_W-1:0]   mon_ch,
    output logic [TEMP_W-1:0] mon_temp,
    output logic [FRAC_W-1:0] mon_frac,
    output logic [NUM_CH-1:0] fault,
    input  logic              fault_clr,
    output logic              scan_done,
    output logic              overrun,
    output logic              busy
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

    typedef struct packed {
        logic [CH_W-1:0] ch;
        sample_t         smp;
    } reading_t;

    scan_state_t       state, state_nxt;
    logic              tick;
    logic [CH_W-1:0]   ch;
    logic [WAIT_W-1:0] wait_cnt;
    reading_t          rd;
    logic              last_ch;
    logic              timed_out;
    logic [NUM_CH-1:0] fault_set;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    assign last_ch   = (ch == LAST_CH);
    // Wait timer runs down from TIMEOUT-1; terminal count without ack faults the channel.
    assign timed_out = (state == ST_REQ) && enable && !smp_ack && (wait_cnt == '0);
    assign fault_set = timed_out ? (NUM_CH'(1) << ch) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!enable)                 state_nxt = ST_IDLE;
                else if (smp_ack)            state_nxt = ST_CAPTURE;
                else if (wait_cnt == '0)     state_nxt = ST_GAP;
            end
            ST_CAPTURE: begin
                state_nxt = enable ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                state_nxt = (!enable || last_ch) ? ST_IDLE : ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        smp_req   = (state == ST_REQ);
        mon_valid = (state == ST_CAPTURE);
        busy      = (state != ST_IDLE);
        scan_done = (state == ST_GAP) && last_ch && enable;
        overrun   = tick && (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch       <= '0;
            wait_cnt <= WAIT_LOAD;
            rd       <= '0;
            fault    <= '0;
        end else begin
            if (state == ST_IDLE && tick) begin
                ch <= '0;
            end else if (state == ST_GAP && enable && !last_ch) begin
                ch <= ch + 1'b1;
            end
            wait_cnt <= (state == ST_REQ) ? wait_cnt - 1'b1 : WAIT_LOAD;
            if (state == ST_REQ && enable && smp_ack) begin
                rd.ch       <= ch;
                rd.smp.temp <= smp_temp;
                rd.smp.frac <= smp_frac;
            end
            // A timeout in the same cycle as fault_clr keeps its own bit set.
            fault <= (fault & ~{NUM_CH{fault_clr}}) | fault_set;
        end
    end

    assign smp_ch   = ch;
    assign mon_ch   = rd.ch;
    assign mon_temp = rd.smp.temp;
    assign mon_frac = rd.smp.frac;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Self-checking bench: reactive sampler, behavioural scan model, directed and random phases.
module tb_sensor_scan_ctrl;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int SCAN_DIV = 16;
    localparam int TIMEOUT  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            smp_req;
    logic [CH_W-1:0] smp_ch;
    logic            smp_ack;
    logic [5:0]      smp_temp;
    logic [3:0]      smp_frac;
    logic            mon_valid;
    logic [CH_W-1:0] mon_ch;
    logic [5:0]      mon_temp;
    logic [3:0]      mon_frac;
    logic [NUM_CH-1:0] fault;
    logic            fault_clr;
    logic            scan_done;
    logic            overrun;
    logic            busy;

    sensor_scan_ctrl #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .smp_req(smp_req), .smp_ch(smp_ch), .smp_ack(smp_ack),
        .smp_temp(smp_temp), .smp_frac(smp_frac),
        .mon_valid(mon_valid), .mon_ch(mon_ch), .mon_temp(mon_temp), .mon_frac(mon_frac),
        .fault(fault), .fault_clr(fault_clr),
        .scan_done(scan_done), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Sampler responder
    logic resp_ack = 1'b0;
    logic resp_clr = 1'b0;
    logic force_ack = 1'b0;
    logic main_clr = 1'b0;
    int   ack_delay = 2;
    int   dead_ch = -1;
    bit   rand_mode = 1'b0;
    bit   clr_at_timeout = 1'b0;
    bit   r_prev = 1'b0;
    int   r_age = 0;
    int   r_delay = 0;

    assign smp_ack   = resp_ack | force_ack;
    assign fault_clr = main_clr | resp_clr;

    always @(posedge clk) begin
        #2;
        if (smp_req) begin
            r_age = r_prev ? r_age + 1 : 0;
            if (!r_prev) r_delay = rand_mode ? int'($urandom_range(0, 9)) : ack_delay;
        end
        r_prev = smp_req;
        if (smp_req)
            resp_ack = (int'(smp_ch) != dead_ch) && (r_age == r_delay);
        else
            resp_ack = rand_mode && ($urandom_range(0, 7) == 0);
        resp_clr = clr_at_timeout && smp_req && (int'(smp_ch) == dead_ch) && (r_age == TIMEOUT - 1);
        if (rand_mode) begin
            smp_temp = 6'($urandom_range(0, 63));
            smp_frac = 4'($urandom_range(0, 15));
        end else begin
            smp_temp = 6'd41;
            smp_frac = 4'd3;
        end
    end

    // Behavioural model: scan in progress = requesting, capturing or gapping one channel.
    bit m_valid = 0;
    int m_cnt = 0, m_age = 0, m_ch = 0, m_fault = 0;
    int m_mch = 0, m_mtemp = 0, m_mfrac = 0;
    bit m_req = 0, m_cap = 0, m_gap = 0;

    always @(posedge clk) begin
        bit tk, bsy;
        if (!rst_n) begin
            m_valid = 1; m_cnt = 0; m_age = 0; m_ch = 0; m_fault = 0;
            m_mch = 0; m_mtemp = 0; m_mfrac = 0; m_req = 0; m_cap = 0; m_gap = 0;
        end else begin
            tk  = enable && (m_cnt == SCAN_DIV - 1);
            bsy = m_req || m_cap || m_gap;
            m_cnt = enable ? (m_cnt + 1) % SCAN_DIV : 0;
            if (fault_clr) m_fault = 0;
            if (!bsy) begin
                if (tk) begin m_req = 1; m_age = 0; m_ch = 0; end
            end else if (m_req) begin
                if (!enable) m_req = 0;
                else if (smp_ack) begin
                    m_mch = m_ch; m_mtemp = int'(smp_temp); m_mfrac = int'(smp_frac);
                    m_req = 0; m_cap = 1;
                end else if (m_age == TIMEOUT - 1) begin
                    m_fault = m_fault | (1 << m_ch); m_req = 0; m_gap = 1;
                end else m_age++;
            end else if (m_cap) begin
                m_cap = 0; m_gap = enable;
            end else begin
                m_gap = 0;
                if (enable && m_ch != NUM_CH - 1) begin m_ch++; m_req = 1; m_age = 0; end
            end
        end
    end

    always @(negedge clk) begin
        bit tk, bsy;
        if (m_valid) begin
            tk  = enable && (m_cnt == SCAN_DIV - 1);
            bsy = m_req || m_cap || m_gap;
            chk("smp_req",   32'(smp_req),   32'(m_req));
            chk("smp_ch",    32'(smp_ch),    m_ch);
            chk("mon_valid", 32'(mon_valid), 32'(m_cap));
            chk("mon_ch",    32'(mon_ch),    m_mch);
            chk("mon_temp",  32'(mon_temp),  m_mtemp);
            chk("mon_frac",  32'(mon_frac),  m_mfrac);
            chk("fault",     32'(fault),     m_fault);
            chk("busy",      32'(busy),      32'(bsy));
            chk("scan_done", 32'(scan_done), 32'(m_gap && m_ch == NUM_CH - 1 && enable));
            chk("overrun",   32'(overrun),   32'(tk && bsy));
        end
    end

    // Scan observation, started at a negedge where the scan's first request is visible
    int beat_ch[$], beat_temp[$], beat_frac[$];
    int ovr_n, run2;
    bit done_seen;

    task automatic collect_scan();
        beat_ch.delete(); beat_temp.delete(); beat_frac.delete();
        ovr_n = 0; run2 = 0; done_seen = 0;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) @(negedge clk);
            if (mon_valid) begin
                beat_ch.push_back(int'(mon_ch));
                beat_temp.push_back(int'(mon_temp));
                beat_frac.push_back(int'(mon_frac));
            end
            if (overrun) ovr_n++;
            if (smp_req && smp_ch == 2'd2) run2++;
            if (scan_done) begin done_seen = 1; break; end
        end
        chk("scan_completes", 32'(done_seen), 32'd1);
    endtask

    task automatic wait_req(input int want_ch, input string nm);
        bit seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (smp_req && (want_ch < 0 || int'(smp_ch) == want_ch)) begin seen = 1; break; end
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  32'(smp_req), 0);
        chk({tag, "_ch"},   32'(smp_ch), 0);
        chk({tag, "_mv"},   32'(mon_valid), 0);
        chk({tag, "_mch"},  32'(mon_ch), 0);
        chk({tag, "_mt"},   32'(mon_temp), 0);
        chk({tag, "_mf"},   32'(mon_frac), 0);
        chk({tag, "_flt"},  32'(fault), 0);
        chk({tag, "_done"}, 32'(scan_done), 0);
        chk({tag, "_ovr"},  32'(overrun), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; enable = 1'b0; smp_temp = 6'd41; smp_frac = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        drive_edge(); rst_n = 1'b1;
        drive_edge(); enable = 1'b1;

        // First request SCAN_DIV cycles after the enable cycle's count starts at 0
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); n++;
            if (smp_req) break;
        end
        chk("first_req_latency", n, 17);
        collect_scan();
        chk("t1_beats", beat_ch.size(), 4);
        if (beat_ch.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("t1_beat_ch", beat_ch[i], i);
                chk("t1_beat_temp", beat_temp[i], 41);
                chk("t1_beat_frac", beat_frac[i], 3);
            end
        chk("t1_fault", 32'(fault), 0);
        chk("t5_overrun_pulses", ovr_n, 1);

        // Ack in the same cycle as the request
        ack_delay = 0;
        wait_req(0, "t2_req_seen");
        chk("t2_ack_same", 32'(smp_ack), 1);
        @(negedge clk);
        chk("t2_mv_next", 32'(mon_valid), 1);
        chk("t2_req_low1", 32'(smp_req), 0);
        @(negedge clk);
        chk("t2_req_low2", 32'(smp_req), 0);
        @(negedge clk);
        chk("t2_req_ch1", 32'(smp_req && smp_ch == 2'd1), 1);
        collect_scan();

        // Channel 2 never answers
        ack_delay = 2; dead_ch = 2;
        wait_req(0, "t3_req_seen");
        collect_scan();
        chk("t3_beats", beat_ch.size(), 3);
        if (beat_ch.size() == 3) begin
            chk("t3_beat0", beat_ch[0], 0);
            chk("t3_beat1", beat_ch[1], 1);
            chk("t3_beat2", beat_ch[2], 3);
        end
        chk("t3_req_len", run2, 8);
        chk("t3_fault", 32'(fault), 32'h4);

        // Clear collides with a fresh timeout, then a clean clear
        clr_at_timeout = 1;
        wait_req(0, "t4_req_seen");
        collect_scan();
        chk("t4_fault_set_wins", 32'(fault), 32'h4);
        clr_at_timeout = 0; dead_ch = -1;
        drive_edge(); enable = 1'b0; main_clr = 1'b1;
        drive_edge(); main_clr = 1'b0;
        @(negedge clk);
        chk("t4_fault_cleared", 32'(fault), 0);

        // Disable while requesting channel 1, late ack ignored
        ack_delay = 5;
        drive_edge(); enable = 1'b1;
        wait_req(1, "t6_req_ch1");
        drive_edge(); enable = 1'b0;
        drive_edge(); force_ack = 1'b1;
        @(negedge clk);
        chk("t6_req_off", 32'(smp_req), 0);
        chk("t6_busy_off", 32'(busy), 0);
        chk("t6_no_done", 32'(scan_done), 0);
        drive_edge();
        @(negedge clk);
        chk("t6_late_ack_ignored", 32'(mon_valid), 0);
        force_ack = 1'b0;

        // Reset during CAPTURE
        ack_delay = 2;
        drive_edge(); enable = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (mon_valid) begin n = 1; break; end
        end
        chk("t7_capture_seen", n, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("t7_rst");
        drive_edge(); rst_n = 1'b1;

        // Randomized traffic
        rand_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            drive_edge();
            if (c % 500 == 0) dead_ch = int'($urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            main_clr = ($urandom_range(0, 49) == 0);
            rst_n = ($urandom_range(0, 999) != 0);
        end
        drive_edge(); rst_n = 1'b1; main_clr = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
